ad9777_cfg_sequencer: RTL and testbench
=======================================

// Module: ad9777_cfg_sequencer
// PURPOSE
//  Upstream feeder for the 16-bit SPI master (spi_controller) driving the AD9777 DAC.
//  Holds a small table of pre-formatted SPI words and, on a go pulse, streams them one by one.
//  For each word it drives start/data/slave-select into the SPI master and waits for data_went.
//  Reports done/error to the top-level init controller.
// PARAMETERS
//  DATA_WIDTH      16    SPI word width (must match SPI master)
//  NUM_WORDS       8     table depth, 1..16
//  GAP_CYCLES      8     idle in_clk cycles between words, >=1
//  TIMEOUT_CYCLES  1023  max cycles to wait for data_went per word
// PORTS
//  in_clk           in   1            system clock
//  in_reset         in   1            asynchronous, active-low reset
//  in_go            in   1            one-cycle request to run the whole table
//  in_ss_sel        in   3            one-hot slave select, sampled on accepted go
//  in_wr_en         in   1            table write strobe
//  in_wr_addr       in   4            table write address (addr >= NUM_WORDS ignored)
//  in_wr_data       in   DATA_WIDTH   table write data
//  in_spi_data_went in   1            one-cycle word-complete pulse from SPI master
//  out_spi_start    out  1            one-cycle start pulse to SPI master
//  out_spi_data     out  DATA_WIDTH   word to SPI master
//  out_select_ss    out  3            slave select to SPI master
//  out_busy         out  1            high from accepted go until DONE/ERR
//  out_done         out  1            one-cycle pulse, all words sent
//  out_error        out  1            sticky timeout flag, cleared by next accepted go
//  out_word_idx     out  4            index of word currently in flight
// BEHAVIOUR
//  Reset: in_reset asynchronous, active-low; clock in_clk. All outputs 0, FSM=IDLE, table cleared to 0.
//  Table writes: accepted only in IDLE, take effect next cycle; ignored while busy.
//  FSM: IDLE -> LOAD -> START -> WAIT -> GAP -> (LOAD | DONE) ; WAIT -> ERR on timeout.
//   IDLE : on in_go: latch in_ss_sel, idx<=0, out_error<=0, out_busy<=1 -> LOAD. in_go elsewhere ignored.
//   LOAD : out_spi_data<=table[idx], out_word_idx<=idx, out_select_ss<=latched sel -> START.
//   START: out_spi_start=1 for exactly one cycle; timeout counter<=0 -> WAIT.
//   WAIT : count cycles; in_spi_data_went -> GAP (gap counter<=0);
//          counter==TIMEOUT_CYCLES-1 with no data_went -> ERR.
//   GAP  : hold GAP_CYCLES cycles; then idx==NUM_WORDS-1 -> DONE, else idx<=idx+1 -> LOAD.
//   DONE : out_done=1 one cycle, out_busy<=0, out_select_ss<=0 -> IDLE.
//   ERR  : out_error<=1 (sticky), out_busy<=0, out_select_ss<=0 -> IDLE.
//  out_spi_data and out_select_ss stable from LOAD through end of GAP (SPI master latches on start).
//  data_went in same cycle as timeout terminal count: data_went wins (-> GAP).
//  data_went outside WAIT ignored.
//  Latency go -> first out_spi_start: 2 cycles (LOAD, START).
//  Per-word overhead excluding SPI time: 2 + GAP_CYCLES cycles.
//  in_go coincident with in_wr_en in IDLE: write performed, run uses updated table only from next word load (LOAD is 1 cycle later, so it sees it).
//  in_ss_sel not one-hot: passed through unchanged (SPI master deasserts all SS).
//  Reset mid-run: immediate return to IDLE, all outputs 0, table cleared.
// TESTING
//  1 Write table[0..7]=16'h0000..16'h0007, go, ss=3'b001, model data_went 40 cyc after start
//    -> 8 start pulses, data in order, out_done once, out_error=0.
//  2 Never pulse data_went -> out_error=1 exactly TIMEOUT_CYCLES after START, busy=0, one start only.
//  3 Assert in_go and in_wr_en while busy -> no restart, table unchanged (readback via next run).
//  4 Check gap: next out_spi_start exactly GAP_CYCLES+2 cycles after data_went.
//  5 Drop in_reset during word 3 -> outputs 0 same cycle, next go restarts at idx 0 with table=0.
//  6 data_went on timeout terminal cycle -> no error, sequence continues.

Source files
------------

// File: rtl/ad9777_cfg_sequencer.sv
// Streams a small table of pre-formatted SPI words into the AD9777 spi_controller on each go request.
// One word in flight at a time; a per-word data_went timeout aborts the run and raises a sticky error.
module ad9777_cfg_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_WORDS      = 8,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  in_go,
  input  logic [2:0]            in_ss_sel,
  input  logic                  in_wr_en,
  input  logic [3:0]            in_wr_addr,
  input  logic [DATA_WIDTH-1:0] in_wr_data,
  input  logic                  in_spi_data_went,
  output logic                  out_spi_start,
  output logic [DATA_WIDTH-1:0] out_spi_data,
  output logic [2:0]            out_select_ss,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_error,
  output logic [3:0]            out_word_idx
);

  localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_table [2**AW];
  logic [3:0]            r_idx;
  logic [2:0]            r_sel;
  logic [TW-1:0]         r_tmo_cnt;
  logic [GW-1:0]         r_gap_cnt;
  logic                  w_tmo_term;
  logic                  w_gap_term;
  logic                  w_last;
  logic                  w_wr_ok;

  assign w_tmo_term = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_gap_term = (r_gap_cnt == GW'(GAP_CYCLES - 1));
  assign w_last     = (r_idx == 4'(NUM_WORDS - 1));
  assign w_wr_ok    = in_wr_en && ({1'b0, in_wr_addr} < 5'(NUM_WORDS));

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    out_spi_start = 1'b0;
    out_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (in_go) w_next = S_LOAD;
      S_LOAD:  w_next = S_START;
      S_START: begin
        out_spi_start = 1'b1;
        w_next        = S_WAIT;
      end
      // data_went on the terminal count still counts as a completed word
      S_WAIT: begin
        if (in_spi_data_went) w_next = S_GAP;
        else if (w_tmo_term)  w_next = S_ERR;
      end
      S_GAP:   if (w_gap_term) w_next = w_last ? S_DONE : S_LOAD;
      S_DONE: begin
        out_done = 1'b1;
        w_next   = S_IDLE;
      end
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      for (int i = 0; i < 2**AW; i++) r_table[i] <= '0;
      r_idx         <= '0;
      r_sel         <= '0;
      r_tmo_cnt     <= '0;
      r_gap_cnt     <= '0;
      out_spi_data  <= '0;
      out_select_ss <= '0;
      out_busy      <= 1'b0;
      out_error     <= 1'b0;
      out_word_idx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_ok) r_table[in_wr_addr[AW-1:0]] <= in_wr_data;
          if (in_go) begin
            r_sel     <= in_ss_sel;
            r_idx     <= '0;
            out_error <= 1'b0;
            out_busy  <= 1'b1;
          end
        end
        // data/select are frozen here until the next LOAD so the SPI master sees stable inputs
        S_LOAD: begin
          out_spi_data  <= r_table[r_idx[AW-1:0]];
          out_word_idx  <= r_idx;
          out_select_ss <= r_sel;
        end
        S_START: r_tmo_cnt <= '0;
        S_WAIT: begin
          if (in_spi_data_went) r_gap_cnt <= '0;
          else if (w_tmo_term)  out_error <= 1'b1;
          else                  r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
        S_GAP: begin
          if (!w_gap_term)  r_gap_cnt <= r_gap_cnt + GW'(1);
          else if (!w_last) r_idx     <= r_idx + 4'd1;
        end
        S_DONE, S_ERR: begin
          out_busy      <= 1'b0;
          out_select_ss <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9777_cfg_sequencer.sv
// Directed bench for ad9777_cfg_sequencer: models the SPI master's data_went reply and checks
// word order, latency, gap, timeout, busy-time lockout and mid-run reset.
module tb_ad9777_cfg_sequencer;

  localparam int DW  = 16;
  localparam int NW  = 8;
  localparam int GAP = 8;
  localparam int TMO = 1023;

  logic          in_clk;
  logic          in_reset;
  logic          in_go;
  logic [2:0]    in_ss_sel;
  logic          in_wr_en;
  logic [3:0]    in_wr_addr;
  logic [DW-1:0] in_wr_data;
  logic          in_spi_data_went;
  logic          out_spi_start;
  logic [DW-1:0] out_spi_data;
  logic [2:0]    out_select_ss;
  logic          out_busy;
  logic          out_done;
  logic          out_error;
  logic [3:0]    out_word_idx;

  ad9777_cfg_sequencer #(
    .DATA_WIDTH    (DW),
    .NUM_WORDS     (NW),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .in_clk          (in_clk),
    .in_reset        (in_reset),
    .in_go           (in_go),
    .in_ss_sel       (in_ss_sel),
    .in_wr_en        (in_wr_en),
    .in_wr_addr      (in_wr_addr),
    .in_wr_data      (in_wr_data),
    .in_spi_data_went(in_spi_data_went),
    .out_spi_start   (out_spi_start),
    .out_spi_data    (out_spi_data),
    .out_select_ss   (out_select_ss),
    .out_busy        (out_busy),
    .out_done        (out_done),
    .out_error       (out_error),
    .out_word_idx    (out_word_idx)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor and SPI-master responder, all on the falling edge
  int          cyc = 0;
  int          starts = 0;
  int          dones = 0;
  int          go_cyc = 0;
  int          err_cyc = 0;
  int          resp_delay = 0;
  int          resp_cnt = 0;
  logic        err_prev = 1'b0;
  logic [15:0] s_data[$];
  logic [3:0]  s_idx[$];
  logic [2:0]  s_sel[$];
  int          s_cyc[$];
  int          w_cyc[$];

  initial forever begin
    @(negedge in_clk);
    cyc++;
    in_spi_data_went = 1'b0;
    if (out_spi_start) begin
      starts++;
      s_data.push_back(out_spi_data);
      s_idx.push_back(out_word_idx);
      s_sel.push_back(out_select_ss);
      s_cyc.push_back(cyc);
      resp_cnt = resp_delay;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        in_spi_data_went = 1'b1;
        w_cyc.push_back(cyc);
      end
    end
    if (out_done) dones++;
    if (in_go && !out_busy) go_cyc = cyc;
    if (out_error && !err_prev) err_cyc = cyc;
    err_prev = out_error;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic clear_mon();
    starts   = 0;
    dones    = 0;
    resp_cnt = 0;
    s_data.delete();
    s_idx.delete();
    s_sel.delete();
    s_cyc.delete();
    w_cyc.delete();
  endtask

  task automatic wr(input logic [3:0] addr, input logic [DW-1:0] data);
    in_wr_en   = 1'b1;
    in_wr_addr = addr;
    in_wr_data = data;
    tick();
    in_wr_en   = 1'b0;
  endtask

  task automatic go(input logic [2:0] sel);
    in_go     = 1'b1;
    in_ss_sel = sel;
    tick();
    in_go     = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (out_busy && n < budget) begin
      tick();
      n++;
    end
    chk_vec("idle_timeout", out_busy, 0);
  endtask

  initial begin
    in_reset   = 1'b0;
    in_go      = 1'b0;
    in_ss_sel  = '0;
    in_wr_en   = 1'b0;
    in_wr_addr = '0;
    in_wr_data = '0;
    in_spi_data_went = 1'b0;
    repeat (3) @(posedge in_clk);
    #1;
    chk_vec("rst_busy", out_busy, 0);
    chk_vec("rst_start", out_spi_start, 0);
    chk_vec("rst_data", out_spi_data, 0);
    chk_vec("rst_ss", out_select_ss, 0);
    chk_vec("rst_err", out_error, 0);
    chk_vec("rst_idx", out_word_idx, 0);
    in_reset = 1'b1;
    tick();
    tick();

    // Full run, table = 0..7; address 8 is outside the table and must not alias onto word 0
    for (int i = 0; i < NW; i++) wr(4'(i), 16'(i));
    wr(4'd8, 16'hFFFF);
    resp_delay = 40;
    clear_mon();
    go(3'b001);
    wait_idle(2000);
    chk_vec("t1_starts", starts, 8);
    chk_vec("t1_dones", dones, 1);
    chk_vec("t1_err", out_error, 0);
    chk_vec("t1_ss_after", out_select_ss, 0);
    chk_vec("t1_latency", s_cyc[0] - go_cyc, 2);
    for (int k = 0; k < NW; k++) begin
      chk_vec($sformatf("t1_data%0d", k), s_data[k], k);
      chk_vec($sformatf("t1_idx%0d", k), s_idx[k], k);
      chk_vec($sformatf("t1_sel%0d", k), s_sel[k], 3'b001);
    end
    chk_vec("t4_gap_w1", s_cyc[1] - w_cyc[0], GAP + 2);
    chk_vec("t4_gap_w7", s_cyc[7] - w_cyc[6], GAP + 2);

    // go and write while busy: no restart, table untouched
    clear_mon();
    go(3'b010);
    repeat (5) tick();
    in_go      = 1'b1;
    in_wr_en   = 1'b1;
    in_wr_addr = 4'd0;
    in_wr_data = 16'hBEEF;
    tick();
    in_go    = 1'b0;
    in_wr_en = 1'b0;
    wait_idle(2000);
    chk_vec("t3_starts", starts, 8);
    chk_vec("t3_dones", dones, 1);
    clear_mon();
    go(3'b001);
    wait_idle(2000);
    chk_vec("t3_rb_w0", s_data[0], 16'h0000);
    chk_vec("t3_rb_w7", s_data[7], 16'h0007);

    // go together with a write in IDLE: first LOAD already sees the new word; odd select passes through
    clear_mon();
    in_go      = 1'b1;
    in_ss_sel  = 3'b110;
    in_wr_en   = 1'b1;
    in_wr_addr = 4'd0;
    in_wr_data = 16'hA5A5;
    tick();
    in_go    = 1'b0;
    in_wr_en = 1'b0;
    wait_idle(2000);
    chk_vec("co_w0", s_data[0], 16'hA5A5);
    chk_vec("co_w1", s_data[1], 16'h0001);
    chk_vec("co_sel", s_sel[0], 3'b110);

    // No data_went at all: error after START plus TMO wait cycles, single start
    resp_delay = 0;
    clear_mon();
    go(3'b001);
    wait_idle(3000);
    chk_vec("t2_err", out_error, 1);
    chk_vec("t2_starts", starts, 1);
    chk_vec("t2_dones", dones, 0);
    chk_vec("t2_ss", out_select_ss, 0);
    chk_vec("t2_err_time", err_cyc - s_cyc[0], TMO + 1);

    // data_went exactly on the terminal wait cycle of every word
    resp_delay = TMO;
    clear_mon();
    go(3'b001);
    chk_vec("t6_err_clr", out_error, 0);
    wait_idle(9500);
    chk_vec("t6_err", out_error, 0);
    chk_vec("t6_starts", starts, 8);
    chk_vec("t6_dones", dones, 1);
    chk_vec("t6_w7", s_data[7], 16'h0007);

    // Reset in the middle of word 3
    resp_delay = 40;
    clear_mon();
    go(3'b100);
    begin
      int n = 0;
      while (out_word_idx != 4'd3 && n < 1000) begin
        tick();
        n++;
      end
    end
    chk_vec("t5_at_w3", out_word_idx, 3);
    #2;
    in_reset = 1'b0;
    #1;
    chk_vec("t5_busy", out_busy, 0);
    chk_vec("t5_data", out_spi_data, 0);
    chk_vec("t5_ss", out_select_ss, 0);
    chk_vec("t5_idx", out_word_idx, 0);
    chk_vec("t5_start", out_spi_start, 0);
    tick();
    in_reset = 1'b1;
    tick();
    clear_mon();
    go(3'b001);
    wait_idle(2000);
    chk_vec("t5_starts", starts, 8);
    chk_vec("t5_idx0", s_idx[0], 0);
    for (int k = 0; k < NW; k++) chk_vec($sformatf("t5_data%0d", k), s_data[k], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
